// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - dual-issue fetch PC sequencer with back-pressure, redirect and end-of-program detection
module fetch_sequencer #(
    parameter int IMEM_BYTES = 1024,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      total_instructions,
    input  logic             ready,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      fetch_addr,
    output logic [1:0]       slot_valid,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] issued_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [33:0] MAX_WORDS = 34'(IMEM_BYTES / 4);

    state_t           state, state_next;
    logic [31:0]      pc, pc_next;
    logic [33:0]      limit, limit_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    logic [33:0]      pc_ext;
    logic             sv0, sv1;
    logic             accept;
    logic [1:0]       pop;
    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W-1:0] cnt_sat;
    logic [33:0]      total_ext, clipped_words, start_limit;
    logic [31:0]      redirect_aligned;
    logic             redirect_in_range;

    always_comb begin
        pc_ext            = {2'b00, pc};
        sv0               = pc_ext < limit;
        sv1               = (pc_ext + 34'd4) < limit;
        accept            = (state == RUN) && (sv0 || sv1) && ready;
        pop               = {1'b0, sv0} + {1'b0, sv1};
        cnt_sum           = {1'b0, cnt} + (CNT_W+1)'(pop);
        cnt_sat           = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
        total_ext         = {2'b00, total_instructions};
        clipped_words     = (total_ext < MAX_WORDS) ? total_ext : MAX_WORDS;
        start_limit       = clipped_words << 2;
        redirect_aligned  = redirect_pc & ~32'd3;
        redirect_in_range = {2'b00, redirect_aligned} < limit;
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        limit_next = limit;
        cnt_next   = cnt;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    pc_next    = 32'd0;
                    cnt_next   = '0;
                    limit_next = start_limit;
                    state_next = (start_limit != 34'd0) ? RUN : DONE;
                end else if (state == DONE && redirect_valid) begin
                    pc_next    = redirect_aligned;
                    state_next = redirect_in_range ? RUN : DONE;
                end
            end
            RUN: begin
                if (accept) begin
                    pc_next    = pc + 32'd8;
                    cnt_next   = cnt_sat;
                    state_next = ((pc_ext + 34'd8) >= limit) ? DONE : RUN;
                end
                // Redirect overrides the sequential PC but the accepted group still counts.
                if (redirect_valid) begin
                    pc_next    = redirect_aligned;
                    state_next = redirect_in_range ? RUN : DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc    <= 32'd0;
            limit <= 34'd0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            limit <= limit_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        busy         = (state == RUN);
        done         = (state == DONE);
        fetch_addr   = busy ? pc : 32'd0;
        slot_valid   = busy ? {sv1, sv0} : 2'b00;
        out_valid    = |slot_valid;
        issued_count = cnt;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control block for the dual-issue instruction fetch stage. It owns the fetch PC and issues one two-instruction fetch group per cycle to the instruction memory read port. It applies downstream back-pressure and branch/flush redirects, and detects end of program from the instruction count. Each group's byte address and per-slot valid bits drive the instruction-memory read and the fetch/decode pipeline register.

## Interface
Parameters:
- `IMEM_BYTES`, default 1024: size of byte-addressed instruction memory; must be a multiple of 8.
- `CNT_W`, default 32: width of `issued_count`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  one-cycle pulse; begins a program run from PC 0.
- `total_instructions`  in  32  instruction count, sampled only on an accepted `start`.
- `ready`  in  1  downstream can accept a group this cycle.
- `redirect_valid`  in  1  flush/branch redirect request.
- `redirect_pc`  in  32  redirect target byte address.
- `fetch_addr`  out  32  byte address of slot 0 (slot 1 = `fetch_addr`+4).
- `slot_valid`  out  2  bit0 = slot 0 valid, bit1 = slot 1 valid.
- `out_valid`  out  1  group offered (OR of `slot_valid`).
- `busy`  out  1  state is RUN.
- `done`  out  1  state is DONE.
- `issued_count`  out  CNT_W  instructions accepted since the last accepted `start`.

## Operation
- States: IDLE, RUN, DONE. Reset puts the block in IDLE.
- Registers: `pc`, `limit` (34-bit), `state`, `issued_count`.
- Limit: `limit` = min(`total_instructions`, `IMEM_BYTES`/4) × 4, computed 34-bit; no wrap.
- IDLE or DONE, `start`=1:
  - `pc`←0, `issued_count`←0, `limit` latched.
  - Next state RUN if `limit`>0, else DONE.
- `start` is ignored in RUN.
- RUN outputs:
  - `fetch_addr`=`pc`.
  - `slot_valid[0]`=(`pc`<`limit`).
  - `slot_valid[1]`=(`pc`+4<`limit`).
- Accept = RUN & `out_valid` & `ready`. On accept:
  - `pc`←`pc`+8.
  - `issued_count` += popcount(`slot_valid`), saturating at all-ones.
  - Next state DONE if `pc`+8 ≥ `limit`.
- `ready`=0 in RUN: `pc`, outputs and count hold; no advance.
- Redirect (`redirect_valid`=1 in RUN or DONE) has priority over the accept `pc` update:
  - `pc`←`redirect_pc` & ~3 (word-aligned; misaligned targets are truncated).
  - Next state RUN if the aligned target < `limit`, else DONE.
  - A group accepted in the same cycle is still counted.
- Redirect in IDLE is ignored.
- `start` and `redirect_valid` together in DONE: `start` wins.
- In IDLE and DONE: `slot_valid`=0, `out_valid`=0, `fetch_addr`=0.
- `total_instructions` changes outside an accepted `start` have no effect.

## Timing
- Reset values, asynchronous:
  - `state`=IDLE, `pc`=0, `limit`=0, `issued_count`=0.
  - All outputs 0.
- All outputs decode from registered state only. There is no combinational path from `ready`, `redirect_*` or `start` to any output.
- `start` sampled at edge N: `out_valid`=1 with `fetch_addr`=0 from N+1.
- Throughput: one group per cycle while `ready`=1.
- Redirect sampled at edge N: the new `fetch_addr` appears from N+1. There are no dead cycles.
- Last group accepted at edge N: `done`=1 and `busy`=0 from N+1.
- Reset asserted mid-RUN: outputs go to 0 immediately, without waiting for a clock edge. After deassertion the block waits in IDLE for `start`.

## Test plan
- Basic run:
  - Stimulus: `total_instructions`=5, `ready`=1.
  - Required: `fetch_addr` 0, 8, 16 with `slot_valid` 11, 11, 01 on cycles 1–3 after `start`.
  - Then `done`=1 and `issued_count`=5.
- Stall:
  - Stimulus: `total_instructions`=4, `ready`=0 for cycles 1–3, then 1.
  - Required: `fetch_addr`=0 and `slot_valid`=11 held for 3 cycles.
  - Then groups at 0 and 8; `done`; `issued_count`=4.
- Redirect:
  - Stimulus: `total_instructions`=16; `redirect_pc`=0x0E during accept of group 8.
  - Required: next `fetch_addr`=0x0C; `issued_count` includes the group at 8.
  - Redirect to 0x100 → DONE next cycle.
  - Redirect to 0x10 from DONE → RUN at 0x10.
- Empty and clipped:
  - `total_instructions`=0 → DONE one cycle after `start`; `out_valid` never asserts.
  - `total_instructions`=1000 with `IMEM_BYTES`=1024 → last group `fetch_addr`=1016, `slot_valid`=11, then `done`.
- Reset mid-run:
  - Stimulus: `reset` asserted in RUN at `pc`=24.
  - Required: all outputs 0 immediately.
  - A new `start` restarts at `fetch_addr`=0 with `issued_count` cleared.
- Restart: a `start` in DONE re-runs from 0 and latches the new `total_instructions`.
